seg_display_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_hex_decoder.sv | 30 +++
 rtl/seg_display_ctrl.sv | 154 +++++++++++++++
 tb/tb_seg_display_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blocks: hex segment patterns,
// the logical "all segments off" value and the default display frame record.
package seg_pkg;

    localparam int SEG_NUM_DIGITS = 8;
    localparam int SEG_BRIGHT_W   = 4;

    // Patterns are {a,b,c,d,e,f,g} with a in bit 6, always active-high here
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

    localparam logic [7:0] SEG_OFF = 8'h00;

    typedef struct packed {
        logic [4*SEG_NUM_DIGITS-1:0] val;
        logic [SEG_NUM_DIGITS-1:0]   dp;
        logic [SEG_NUM_DIGITS-1:0]   blank;
        logic [SEG_BRIGHT_W-1:0]     bright;
    } type_seg_frame_s;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to seven-segment pattern ({a..g}, active-high).
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (nibble_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            default: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment controller with double-buffered frame load and PWM brightness.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int CLK_DIV     = 200000,
    parameter int BRIGHT_W    = 4,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [4*NUM_DIGITS-1:0] val_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic [BRIGHT_W-1:0]     bright_i,
    output logic [7:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [DIG_W-1:0]      DIG_MAX  = DIG_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      STEP     = CNT_W'(CLK_DIV >> BRIGHT_W);
    localparam logic [7:0]            SEG_IDLE = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_ACT_LOW ? '1 : '0;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] val;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
        logic [BRIGHT_W-1:0]     bright;
    } frame_t;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIG_W-1:0]      digit_q, digit_d;
    frame_t                pend_q, pend_d;
    frame_t                act_q, act_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  frame_q, frame_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  tick, wrap, lit;
    logic [NUM_DIGITS-1:0] dark;
    logic [CNT_W-1:0]      duty;
    logic [6:0]            hex_seg;
    logic [7:0]            seg_logic;
    logic [NUM_DIGITS-1:0] an_logic;

    assign tick = (cnt_q == CNT_MAX);
    assign wrap = tick && (digit_q == DIG_MAX);

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        digit_d = digit_q;
        if (tick) begin
            cnt_d   = '0;
            digit_d = wrap ? '0 : digit_q + 1'b1;
        end
    end

    // Commit only ever happens with a full pending buffer and accept only with an
    // empty one, so the two branches below can never fight over pend_vld_d.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        act_d      = act_q;
        frame_d    = wrap;
        if (wrap && pend_vld_q) begin
            act_d      = pend_q;
            pend_vld_d = 1'b0;
        end
        if (wr_valid_i && !pend_vld_q) begin
            pend_d.val    = val_i;
            pend_d.dp     = dp_i;
            pend_d.blank  = blank_i;
            pend_d.bright = bright_i;
            pend_vld_d    = 1'b1;
        end
    end

`ifdef SEG_LZB_EN
    // Scan from the top digit down; once a significant digit is seen nothing below blanks.
    always_comb begin
        logic seen;
        seen = 1'b0;
        dark = act_q.blank;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if ((act_q.val[4*i +: 4] != 4'h0) || act_q.dp[i]) begin
                seen = 1'b1;
            end
            if (!seen) begin
                dark[i] = 1'b1;
            end
        end
    end
`else
    assign dark = act_q.blank;
`endif

    seg_hex_decoder u_hex (
        .nibble_i (act_q.val[{digit_q, 2'b00} +: 4]),
        .seg_o    (hex_seg)
    );

    assign duty = CNT_W'(act_q.bright) * STEP;
    assign lit  = !dark[digit_q] && ((&act_q.bright) || (cnt_q < duty));

    always_comb begin
        seg_logic = SEG_OFF;
        an_logic  = '0;
        if (lit) begin
            seg_logic = {act_q.dp[digit_q], hex_seg};
            an_logic  = NUM_DIGITS'(1) << digit_q;
        end
        seg_d = SEG_ACT_LOW ? ~seg_logic : seg_logic;
        an_d  = AN_ACT_LOW ? ~an_logic : an_logic;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            digit_q    <= '0;
            pend_q     <= '0;
            act_q      <= '0;
            pend_vld_q <= 1'b0;
            frame_q    <= 1'b0;
            seg_q      <= SEG_IDLE;
            an_q       <= AN_IDLE;
        end else begin
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            pend_q     <= pend_d;
            act_q      <= act_d;
            pend_vld_q <= pend_vld_d;
            frame_q    <= frame_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign wr_ready_o = ~pend_vld_q;
    assign frame_o    = frame_q;
    assign seg_o      = seg_q;
    assign an_o       = an_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl (4 digits, 64-cycle slots, active-low outputs).
// Honours SEG_LZB_EN in both the reference model and the hand-written expectations.
module tb_seg_display_ctrl;

    localparam int N    = 4;
    localparam int DIV  = 64;
    localparam int BW   = 4;
    localparam int W    = N * DIV;
    localparam int STEP = DIV >> BW;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  bright;
    } frameRec;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  bright;
        int          digit;
        logic [7:0]  expSeg;
        logic [3:0]  expAn;
        string       name;
    } vecRec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid_i = 1'b0;
    logic        wr_ready_o;
    logic [15:0] val_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blank_i = '0;
    logic [3:0]  bright_i = '0;
    logic [7:0]  seg_o;
    logic [3:0]  an_o;
    logic        frame_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_display_ctrl #(
        .NUM_DIGITS  (N),
        .CLK_DIV     (DIV),
        .BRIGHT_W    (BW),
        .SEG_ACT_LOW (1'b1),
        .AN_ACT_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .val_i      (val_i),
        .dp_i       (dp_i),
        .blank_i    (blank_i),
        .bright_i   (bright_i),
        .seg_o      (seg_o),
        .an_o       (an_o),
        .frame_o    (frame_o)
    );

    function automatic logic [6:0] hexRef(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    // A digit is lit when it is not blanked and the slot position lies inside its duty window
    function automatic bit litRef(input int mm, input frameRec f);
        int  cnt;
        int  d;
        bit  dark;
        cnt  = mm % DIV;
        d    = (mm / DIV) % N;
        dark = f.blank[d];
`ifdef SEG_LZB_EN
        begin
            int top;
            top = 0;
            for (int i = 0; i < N; i++) begin
                if (f.val[4*i +: 4] != 4'h0 || f.dp[i]) top = i;
            end
            if (d > top) dark = 1'b1;
        end
`endif
        return !dark && (f.bright == 4'hF || cnt < int'(f.bright) * STEP);
    endfunction

    function automatic logic [7:0] segRef(input int mm, input frameRec f);
        int d;
        d = (mm / DIV) % N;
        if (litRef(mm, f)) return ~{f.dp[d], hexRef(f.val[4*d +: 4])};
        return 8'hFF;
    endfunction

    function automatic logic [3:0] anRef(input int mm, input frameRec f);
        int d;
        d = (mm / DIV) % N;
        if (litRef(mm, f)) return ~(4'b0001 << d);
        return 4'hF;
    endfunction

    function automatic bit pendNext(input bit pv, input bit wrapNow, input bit valid);
        return pv ? !wrapNow : valid;
    endfunction

    // Reference model: m counts slot positions since reset; frames move pending -> active at scan ends
    int         m = 0;
    frameRec    act = '{16'h0, 4'h0, 4'h0, 4'h0};
    frameRec    pend = '{16'h0, 4'h0, 4'h0, 4'h0};
    bit         pendValid = 1'b0;
    logic [7:0] expSeg = 8'hFF;
    logic [3:0] expAn = 4'hF;
    logic       expFrame = 1'b0;
    logic       expReady = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m         <= 0;
            act       <= '{16'h0, 4'h0, 4'h0, 4'h0};
            pendValid <= 1'b0;
            expSeg    <= 8'hFF;
            expAn     <= 4'hF;
            expFrame  <= 1'b0;
            expReady  <= 1'b1;
        end else begin
            expSeg    <= segRef(m, act);
            expAn     <= anRef(m, act);
            expFrame  <= (m % W == W - 1);
            if ((m % W == W - 1) && pendValid) act <= pend;
            if (wr_valid_i && !pendValid) pend <= '{val_i, dp_i, blank_i, bright_i};
            pendValid <= pendNext(pendValid, (m % W == W - 1), wr_valid_i);
            expReady  <= !pendNext(pendValid, (m % W == W - 1), wr_valid_i);
            m         <= m + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one clock and compare every output against the model away from the active edge
    task automatic stepCycle();
        @(negedge clk);
        checkOutput("model seg", seg_o, expSeg);
        checkOutput("model an", an_o, expAn);
        checkOutput("model frame", frame_o, expFrame);
        checkOutput("model ready", wr_ready_o, expReady);
    endtask

    task automatic applyStimulus(input frameRec f);
        val_i    = f.val;
        dp_i     = f.dp;
        blank_i  = f.blank;
        bright_i = f.bright;
    endtask

    task automatic loadFrame(input frameRec f);
        bit accepted;
        accepted = 1'b0;
        applyStimulus(f);
        wr_valid_i = 1'b1;
        for (int n = 0; n < 2 * W + 8; n++) begin
            accepted = wr_ready_o;
            stepCycle();
            if (accepted) break;
        end
        wr_valid_i = 1'b0;
        checkOutput("load accepted", accepted, 1'b1);
    endtask

    task automatic waitReady(output int steps);
        steps = 0;
        while (!wr_ready_o && steps < W + 8) begin
            stepCycle();
            steps++;
        end
        checkOutput("ready timeout", wr_ready_o, 1'b1);
    endtask

    task automatic checkScan(input string name, input logic [7:0] segs[4], input logic [3:0] ans[4]);
        int steps;
        waitReady(steps);
        stepCycle();
        for (int d = 0; d < N; d++) begin
            checkOutput({name, " seg"}, seg_o, segs[d]);
            checkOutput({name, " an"}, an_o, ans[d]);
            repeat (DIV) stepCycle();
        end
    endtask

    vecRec      vecs[8];
    frameRec    fr;
    int         n;
    int         litCnt[4];
    logic [7:0] segs[4];
    logic [3:0] ans[4];

    initial begin
        vecs[0] = '{16'h12AF, 4'h0, 4'h0,    4'hF, 0, 8'hB8, 4'hE, "12AF d0"};
        vecs[1] = '{16'h12AF, 4'h0, 4'h0,    4'hF, 3, 8'hCF, 4'h7, "12AF d3"};
        vecs[2] = '{16'h8421, 4'h1, 4'b0100, 4'hF, 2, 8'hFF, 4'hF, "blank d2"};
        vecs[3] = '{16'h8421, 4'h1, 4'b0100, 4'hF, 0, 8'h4F, 4'hE, "dp d0"};
        vecs[4] = '{16'h9C5E, 4'h0, 4'h0,    4'h8, 1, 8'hA4, 4'hD, "half d1"};
        vecs[5] = '{16'h7777, 4'h0, 4'h0,    4'h0, 2, 8'hFF, 4'hF, "bright0 d2"};
        vecs[6] = '{16'hDB36, 4'h0, 4'h0,    4'hF, 3, 8'hC2, 4'h7, "DB36 d3"};
        vecs[7] = '{16'h4E0A, 4'h4, 4'h0,    4'h3, 2, 8'h30, 4'hB, "dp d2"};

        repeat (3) stepCycle();
        checkOutput("reset an", an_o, 4'hF);
        checkOutput("reset seg", seg_o, 8'hFF);
        checkOutput("reset ready", wr_ready_o, 1'b1);
        checkOutput("reset frame", frame_o, 1'b0);
        rst = 1'b0;

        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                stepCycle();
                n++;
            end while (!frame_o && n < W + 8);
            checkOutput("frame period", n, W);
        end

        for (int i = 0; i < 8; i++) begin
            loadFrame('{vecs[i].val, vecs[i].dp, vecs[i].blank, vecs[i].bright});
            waitReady(n);
            stepCycle();
            repeat (vecs[i].digit * DIV) stepCycle();
            checkOutput({vecs[i].name, " seg"}, seg_o, vecs[i].expSeg);
            checkOutput({vecs[i].name, " an"}, an_o, vecs[i].expAn);
        end

        // Back-to-back: the second offer is held off until the first commits
        loadFrame('{16'h1234, 4'h0, 4'h0, 4'hF});
        applyStimulus('{16'hABCD, 4'h2, 4'h0, 4'hF});
        wr_valid_i = 1'b1;
        checkOutput("b2b held off", wr_ready_o, 1'b0);
        n = 0;
        while (!wr_ready_o && n < W + 8) begin
            stepCycle();
            n++;
        end
        stepCycle();
        wr_valid_i = 1'b0;
        checkOutput("b2b second pending", wr_ready_o, 1'b0);
        waitReady(n);
        checkOutput("b2b scan length", n, W - 1);

        // PWM duty: bright=4 lights each digit for 16 of its 64 slot cycles
        foreach (litCnt[i]) litCnt[i] = 0;
        loadFrame('{16'hFFFF, 4'h0, 4'h0, 4'h4});
        waitReady(n);
        stepCycle();
        for (int k = 0; k < W; k++) begin
            for (int i = 0; i < N; i++) if (!an_o[i]) litCnt[i]++;
            stepCycle();
        end
        for (int i = 0; i < N; i++) checkOutput("pwm duty", litCnt[i], 16);

        n = 0;
        loadFrame('{16'hFFFF, 4'h0, 4'h0, 4'h0});
        waitReady(n);
        stepCycle();
        n = 0;
        for (int k = 0; k < W; k++) begin
            if (an_o != 4'hF) n++;
            stepCycle();
        end
        checkOutput("bright0 dark", n, 0);

`ifdef SEG_LZB_EN
        segs = '{8'h81, 8'h86, 8'hFF, 8'hFF};
        ans  = '{4'hE, 4'hD, 4'hF, 4'hF};
`else
        segs = '{8'h81, 8'h86, 8'h81, 8'h81};
        ans  = '{4'hE, 4'hD, 4'hB, 4'h7};
`endif
        loadFrame('{16'h0030, 4'h0, 4'h0, 4'hF});
        checkScan("lzb 0030", segs, ans);

`ifdef SEG_LZB_EN
        segs = '{8'h81, 8'hFF, 8'hFF, 8'hFF};
        ans  = '{4'hE, 4'hF, 4'hF, 4'hF};
`else
        segs = '{8'h81, 8'h81, 8'h81, 8'h81};
        ans  = '{4'hE, 4'hD, 4'hB, 4'h7};
`endif
        loadFrame('{16'h0000, 4'h0, 4'h0, 4'hF});
        checkScan("lzb 0000", segs, ans);

        // Random traffic against the model
        for (int k = 0; k < 3 * W; k++) begin
            fr.val    = 16'($urandom) >> (4 * $urandom_range(0, 4));
            fr.dp     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            fr.blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            fr.bright = 4'($urandom);
            applyStimulus(fr);
            wr_valid_i = ($urandom_range(0, 5) == 0);
            stepCycle();
        end
        wr_valid_i = 1'b0;

        // Asynchronous reset mid-slot drops the pending frame
        loadFrame('{16'h5678, 4'hF, 4'h0, 4'hF});
        waitReady(n);
        loadFrame('{16'h9999, 4'h0, 4'h0, 4'hF});
        checkOutput("pre-reset pending", wr_ready_o, 1'b0);
        repeat (20) stepCycle();
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset an", an_o, 4'hF);
        checkOutput("async reset seg", seg_o, 8'hFF);
        checkOutput("async reset ready", wr_ready_o, 1'b1);
        checkOutput("async reset frame", frame_o, 1'b0);
        repeat (2) stepCycle();
        rst = 1'b0;
        repeat (W + 8) stepCycle();
        checkOutput("post-reset an", an_o, 4'hF);
        checkOutput("post-reset ready", wr_ready_o, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
